enemy_sprite_scheduler: RTL

//  Per-scanline scheduler that shares ONE enemy sprite ROM (9x7 px, 8-bit R/G/B, black = transparent)

---
 rtl/enemy_sprite_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/enemy_sprite_scheduler.sv
// Per-scanline enemy sprite scheduler: scans the enemy table during hblank into a small slot list,
// then arbitrates the shared sprite ROM per pixel and registers the resulting colour and hit flag.
module enemy_sprite_scheduler #(
  parameter  int unsigned NUM_ENEMIES = 8,
  parameter  int unsigned MAX_SLOTS   = 4,
  parameter  int unsigned SPR_W       = 9,
  parameter  int unsigned SPR_H       = 7,
  parameter  int unsigned POS_W       = 10,
  localparam int unsigned IDXW        = $clog2(NUM_ENEMIES)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             LineStart,
  input  logic [POS_W-1:0] DrawY,
  input  logic [POS_W-1:0] DrawX,
  input  logic             PixelValid,
  output logic [IDXW-1:0]  EnemyIdx,
  input  logic [POS_W-1:0] EnemyX,
  input  logic [POS_W-1:0] EnemyY,
  input  logic             EnemyAlive,
  output logic [8:0]       SpriteX,
  output logic [8:0]       SpriteY,
  input  logic [7:0]       SpriteR,
  input  logic [7:0]       SpriteG,
  input  logic [7:0]       SpriteB,
  output logic [7:0]       PixelR,
  output logic [7:0]       PixelG,
  output logic [7:0]       PixelB,
  output logic             PixelHit,
  output logic             ScanDone,
  output logic             Overflow
);
  localparam int unsigned DYW  = $clog2(SPR_H);
  localparam int unsigned CNTW = $clog2(NUM_ENEMIES + 1);
  localparam int unsigned SLW  = $clog2(MAX_SLOTS + 1);
  localparam int unsigned SIW  = $clog2(MAX_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [POS_W-1:0]     r_line_y;
  logic [IDXW-1:0]      r_enemy_idx;
  logic [CNTW-1:0]      r_cnt;
  logic [SLW-1:0]       r_nslots;
  logic [MAX_SLOTS-1:0] r_slot_v;
  logic [POS_W-1:0]     r_slot_x  [MAX_SLOTS];
  logic [DYW-1:0]       r_slot_dy [MAX_SLOTS];
  logic                 r_scan_done;
  logic                 r_overflow;
  logic                 r_pix_hit;
  logic [7:0]           r_pix_r;
  logic [7:0]           r_pix_g;
  logic [7:0]           r_pix_b;

  logic [POS_W-1:0]     w_dy;
  logic                 w_eval;
  logic                 w_last;
  logic                 w_visible;
  logic [SIW-1:0]       w_slot_sel;
  logic                 w_cover;
  logic                 w_win;
  logic [POS_W-1:0]     w_dx;
  logic [POS_W-1:0]     w_win_dx;
  logic [DYW-1:0]       w_win_dy;

  // Table data lags EnemyIdx by one cycle, so r_cnt = k+1 marks entry k on the inputs.
  assign w_dy       = r_line_y - EnemyY;
  assign w_eval     = (r_state == S_SCAN) && (r_cnt != '0);
  assign w_last     = (r_state == S_SCAN) && (r_cnt == CNTW'(NUM_ENEMIES));
  assign w_visible  = w_eval && EnemyAlive && (w_dy < POS_W'(SPR_H));
  assign w_slot_sel = SIW'(r_nslots);

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (LineStart)   w_state_nxt = S_SCAN;
    else if (w_last) w_state_nxt = S_DONE;
  end

  // Scan datapath: slots fill in table order; extras only raise Overflow.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_line_y    <= '0;
      r_enemy_idx <= '0;
      r_cnt       <= '0;
      r_nslots    <= '0;
      r_slot_v    <= '0;
      r_scan_done <= 1'b0;
      r_overflow  <= 1'b0;
      for (int s = 0; s < MAX_SLOTS; s++) begin
        r_slot_x[s]  <= '0;
        r_slot_dy[s] <= '0;
      end
    end else if (LineStart) begin
      r_line_y    <= DrawY;
      r_enemy_idx <= '0;
      r_cnt       <= '0;
      r_nslots    <= '0;
      r_slot_v    <= '0;
      r_scan_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (r_state == S_SCAN) begin
      r_cnt <= r_cnt + CNTW'(1);
      if (r_enemy_idx != IDXW'(NUM_ENEMIES - 1)) r_enemy_idx <= r_enemy_idx + IDXW'(1);
      if (w_visible) begin
        if (r_nslots < SLW'(MAX_SLOTS)) begin
          r_slot_v[w_slot_sel]  <= 1'b1;
          r_slot_x[w_slot_sel]  <= EnemyX;
          r_slot_dy[w_slot_sel] <= DYW'(w_dy);
          r_nslots              <= r_nslots + SLW'(1);
        end else begin
          r_overflow <= 1'b1;
        end
      end
      if (w_last) r_scan_done <= 1'b1;
    end
  end

  // Lowest covering slot wins; iterate high-to-low so the lowest overrides.
  always_comb begin
    w_cover  = 1'b0;
    w_dx     = '0;
    w_win_dx = '0;
    w_win_dy = '0;
    for (int s = MAX_SLOTS - 1; s >= 0; s--) begin
      w_dx = DrawX - r_slot_x[s];
      if (r_slot_v[s] && (w_dx < POS_W'(SPR_W))) begin
        w_cover  = 1'b1;
        w_win_dx = w_dx;
        w_win_dy = r_slot_dy[s];
      end
    end
  end

  assign w_win   = w_cover && PixelValid && (r_state == S_DONE);
  assign SpriteX = w_win ? 9'(w_win_dx) : '0;
  assign SpriteY = w_win ? 9'(w_win_dy) : '0;

  always_ff @(posedge Clk) begin
    if (!Reset_n || !w_win) begin
      r_pix_r   <= '0;
      r_pix_g   <= '0;
      r_pix_b   <= '0;
      r_pix_hit <= 1'b0;
    end else begin
      r_pix_r   <= SpriteR;
      r_pix_g   <= SpriteG;
      r_pix_b   <= SpriteB;
      r_pix_hit <= |{SpriteR, SpriteG, SpriteB};
    end
  end

  assign EnemyIdx = r_enemy_idx;
  assign ScanDone = r_scan_done;
  assign Overflow = r_overflow;
  assign PixelHit = r_pix_hit;
  assign PixelR   = r_pix_r;
  assign PixelG   = r_pix_g;
  assign PixelB   = r_pix_b;

endmodule
